// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forward-select codes and
// divider stall FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divider stall sequencer. It holds the front of the pipe while the
// divider runs, then presents one DONE cycle (longer if memory is stalling).
//   state | meaning
//   IDLE  | no divide in flight
//   BUSY  | divider running, counter counts down to zero
//   DONE  | result valid, E latches it; held while memory stalls
module div_stall_fsm #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic hold,
    output logic busy,
    output logic done,
    output logic stall_req
);
    import hazard_pkg::*;

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                // an exception kills the divide; memory stalls do not pause it
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (abort || !hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign stall_req = ((state_q == IDLE) && start) || (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: forwarding into D and E, load-use and
// branch stalls, divider/memory stalls and exception flushing.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoRegE,
    input  logic              memtoRegM,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] reg_waddrE,
    input  logic [REG_AW-1:0] reg_waddrM,
    input  logic [REG_AW-1:0] reg_waddrW,
    input  logic              errorM,
    input  logic              div_startE,
    input  logic              mem_stallM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic [1:0]        forwardAD,
    output logic [1:0]        forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              div_busy,
    output logic              div_doneE
);
    import hazard_pkg::*;

    logic lwstall;
    logic brstall;
    logic divstall;

    // M is the younger result, so it wins when both M and W match
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              wr_m,
        input logic [REG_AW-1:0] addr_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] addr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (wr_m && (src == addr_m)) begin
                sel = FWD_M;
            end else if (wr_w && (src == addr_w)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    assign forwardAE = fwd_sel(rsE, regwriteM, reg_waddrM, regwriteW, reg_waddrW);
    assign forwardBE = fwd_sel(rtE, regwriteM, reg_waddrM, regwriteW, reg_waddrW);
    assign forwardAD = fwd_sel(rsD, regwriteM, reg_waddrM, regwriteW, reg_waddrW);
    assign forwardBD = fwd_sel(rtD, regwriteM, reg_waddrM, regwriteW, reg_waddrW);

    assign lwstall = memtoRegE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));

    assign brstall = branchD &&
        ((regwriteE && (reg_waddrE != '0) && ((rsD == reg_waddrE) || (rtD == reg_waddrE))) ||
         (memtoRegM && (reg_waddrM != '0) && ((rsD == reg_waddrM) || (rtD == reg_waddrM))));

    div_stall_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (div_startE),
        .abort     (errorM),
        .hold      (mem_stallM),
        .busy      (div_busy),
        .done      (div_doneE),
        .stall_req (divstall)
    );

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (errorM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mem_stallM) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (divstall) begin
            // M drains while the divide occupies E, so it must see bubbles
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstall || brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with DIV_CYCLES=4; expected output vectors are
// queued as each cycle is driven and compared at the following falling edge.
module tb_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          regwriteE, regwriteM, regwriteW;
    logic          memtoRegE, memtoRegM, branchD;
    logic [AW-1:0] rsD, rtD, rsE, rtE;
    logic [AW-1:0] reg_waddrE, reg_waddrM, reg_waddrW;
    logic          errorM, div_startE, mem_stallM;
    logic          stallF, stallD, stallE, stallM;
    logic          flushD, flushE, flushM;
    logic [1:0]    forwardAD, forwardBD, forwardAE, forwardBE;
    logic          div_busy, div_doneE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoRegE(memtoRegE), .memtoRegM(memtoRegM), .branchD(branchD),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .reg_waddrE(reg_waddrE), .reg_waddrM(reg_waddrM), .reg_waddrW(reg_waddrW),
        .errorM(errorM), .div_startE(div_startE), .mem_stallM(mem_stallM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .div_busy(div_busy), .div_doneE(div_doneE)
    );

    // {stallF,D,E,M} {flushD,E,M} AD BD AE BE busy done
    function automatic logic [16:0] ev(input logic [3:0] st, input logic [2:0] fl,
                                       input logic [1:0] ad, input logic [1:0] bd,
                                       input logic [1:0] ae, input logic [1:0] be,
                                       input logic busy, input logic done);
        return {st, fl, ad, bd, ae, be, busy, done};
    endfunction

    task automatic clear_inputs();
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoRegE = 0; memtoRegM = 0; branchD = 0;
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        reg_waddrE = '0; reg_waddrM = '0; reg_waddrW = '0;
        errorM = 0; div_startE = 0; mem_stallM = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [16:0] e);
        sb_t item;
        logic [16:0] obs;
        sb.push_back('{tag: tag, exp: e});
        @(negedge clk);
        obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushM,
               forwardAD, forwardBD, forwardAE, forwardBE, div_busy, div_doneE};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            item = sb.pop_front();
            assert (obs === item.exp) else begin
                errors++;
                $error("FAIL %s observed=%05h expected=%05h", item.tag, obs, item.exp);
            end
        end
    endtask

    localparam logic [3:0] S_NONE = 4'b0000, S_LD = 4'b1100, S_DIV = 4'b1110, S_ALL = 4'b1111;
    localparam logic [2:0] F_NONE = 3'b000, F_E = 3'b010, F_M = 3'b001, F_ALL = 3'b111;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        expect_out("reset_zero", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle(); rst = 0;
        expect_out("idle_zero", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // forwarding into E
        next_cycle();
        regwriteM = 1; reg_waddrM = 8; regwriteW = 1; reg_waddrW = 8; rsE = 8;
        expect_out("fwdAE_m_wins", ev(S_NONE, F_NONE, 0, 0, 2'b10, 0, 0, 0));
        next_cycle(); reg_waddrM = 3;
        expect_out("fwdAE_w", ev(S_NONE, F_NONE, 0, 0, 2'b01, 0, 0, 0));
        next_cycle(); rsE = 0; reg_waddrW = 0;
        expect_out("fwdAE_r0", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle(); reg_waddrW = 8; regwriteW = 0; rtE = 8;
        expect_out("fwdBE_no_regwrite", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle(); regwriteW = 1; rtE = 0; rsD = 8;
        expect_out("fwdAD_w", ev(S_NONE, F_NONE, 2'b01, 0, 0, 0, 0, 0));

        // load-use
        next_cycle(); clear_inputs();
        memtoRegE = 1; rtE = 5; rsD = 5;
        expect_out("lwstall", ev(S_LD, F_E, 0, 0, 0, 0, 0, 0));
        next_cycle(); memtoRegE = 0;
        expect_out("lwstall_release", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle(); memtoRegE = 1; rtE = 0; rsD = 0;
        expect_out("lwstall_r0", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // branch
        next_cycle(); clear_inputs();
        branchD = 1; regwriteE = 1; reg_waddrE = 9; rtD = 9;
        expect_out("brstall_e", ev(S_LD, F_E, 0, 0, 0, 0, 0, 0));
        next_cycle(); regwriteE = 0; reg_waddrE = 0; regwriteM = 1; reg_waddrM = 9;
        expect_out("br_fwdBD_m", ev(S_NONE, F_NONE, 0, 2'b10, 0, 0, 0, 0));
        next_cycle(); memtoRegM = 1;
        expect_out("brstall_load_m", ev(S_LD, F_E, 0, 2'b10, 0, 0, 0, 0));

        // divide, start held during BUSY (ignored while not IDLE)
        next_cycle(); clear_inputs(); div_startE = 1;
        expect_out("div_t0", ev(S_DIV, F_M, 0, 0, 0, 0, 0, 0));
        next_cycle();
        expect_out("div_t1", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle();
        expect_out("div_t2", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle();
        expect_out("div_t3", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle(); div_startE = 0;
        expect_out("div_t4_done", ev(S_NONE, F_NONE, 0, 0, 0, 0, 1, 1));
        next_cycle();
        expect_out("div_t5_idle", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // divide with memory stalls in BUSY and in DONE
        next_cycle(); div_startE = 1;
        expect_out("div2_t0", ev(S_DIV, F_M, 0, 0, 0, 0, 0, 0));
        next_cycle(); div_startE = 0;
        expect_out("div2_t1", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle(); mem_stallM = 1;
        expect_out("div2_t2_memstall", ev(S_ALL, F_NONE, 0, 0, 0, 0, 1, 0));
        next_cycle(); mem_stallM = 0;
        expect_out("div2_t3", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle(); mem_stallM = 1;
        expect_out("div2_t4_done_hold", ev(S_ALL, F_NONE, 0, 0, 0, 0, 1, 1));
        next_cycle();
        expect_out("div2_t5_done_hold", ev(S_ALL, F_NONE, 0, 0, 0, 0, 1, 1));
        next_cycle(); mem_stallM = 0;
        expect_out("div2_t6_done", ev(S_NONE, F_NONE, 0, 0, 0, 0, 1, 1));
        next_cycle();
        expect_out("div2_t7_idle", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // abort during BUSY
        next_cycle(); div_startE = 1;
        expect_out("abort_t0", ev(S_DIV, F_M, 0, 0, 0, 0, 0, 0));
        next_cycle(); div_startE = 0;
        expect_out("abort_t1", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle(); errorM = 1;
        expect_out("abort_t2_flush", ev(S_NONE, F_ALL, 0, 0, 0, 0, 1, 0));
        next_cycle(); errorM = 0;
        expect_out("abort_t3_idle", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle();
        expect_out("abort_t4_no_done", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // error coincident with start: no divide
        next_cycle(); div_startE = 1; errorM = 1;
        expect_out("err_start_flush", ev(S_NONE, F_ALL, 0, 0, 0, 0, 0, 0));
        next_cycle(); div_startE = 0; errorM = 0;
        expect_out("err_start_idle", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // reset mid-divide
        next_cycle(); div_startE = 1;
        expect_out("rst_t0", ev(S_DIV, F_M, 0, 0, 0, 0, 0, 0));
        next_cycle(); div_startE = 0;
        expect_out("rst_t1", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle(); rst = 1;
        expect_out("rst_t2_pre_edge", ev(S_DIV, F_M, 0, 0, 0, 0, 1, 0));
        next_cycle();
        expect_out("rst_t3_idle", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle(); rst = 0;
        expect_out("rst_t4_no_done", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle();
        expect_out("rst_t5_no_done", ev(S_NONE, F_NONE, 0, 0, 0, 0, 0, 0));

        // priority ordering
        next_cycle(); clear_inputs();
        errorM = 1; mem_stallM = 1; memtoRegE = 1; rtE = 5; rsD = 5;
        expect_out("prio_error", ev(S_NONE, F_ALL, 0, 0, 0, 0, 0, 0));
        next_cycle(); errorM = 0;
        expect_out("prio_memstall", ev(S_ALL, F_NONE, 0, 0, 0, 0, 0, 0));
        next_cycle(); mem_stallM = 0;
        expect_out("prio_lwstall", ev(S_LD, F_E, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
